// File: rtl/stim_pkg.sv
// stim_pkg: shared sizes, opcode field positions and playback states for stim_player
package stim_pkg;
    localparam int DEPTH = 501;
    localparam int AW = 9;
    localparam int OPW = 6;
    localparam int OBS_BIT = 5;
    localparam int K_MSB = 4;
    localparam int K_LSB = 1;
    localparam int START_BIT = 0;
    localparam int KW = K_MSB - K_LSB + 1;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
endpackage

// File: rtl/stim_ram.sv
// stim_ram: opcode store, one write port and a combinational read port
module stim_ram
    import stim_pkg::*;
(
    input  logic           clock,
    input  logic           we,
    input  logic [AW-1:0]  wr_addr,
    input  logic [OPW-1:0] wr_data,
    input  logic [AW-1:0]  rd_addr,
    output logic [OPW-1:0] rd_data
);
    logic [OPW-1:0] mem [DEPTH];
    always_ff @(posedge clock)
        if (we) mem[wr_addr] <= wr_data;
    assign rd_data = (rd_addr < AW'(DEPTH)) ? mem[rd_addr] : '0;
endmodule

// File: rtl/stim_player.sv
// stim_player: plays a loaded opcode program out as registered game-core stimulus
// Define STIM_PLAYER_LOOP_EN to replay the program endlessly instead of a single pass.
module stim_player
    import stim_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [OPW-1:0] wr_data,
    input  logic [AW-1:0]  len,
    input  logic           go,
    input  logic           stall,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic [AW-1:0]  pc,
    output logic [KW-1:0]  k,
    output logic           start,
    output logic           obs
);
    state_t state;
    logic [AW-1:0] last;
    logic [AW-1:0] lim;
    logic [OPW-1:0] op;
    logic we;
    assign lim = (len > AW'(DEPTH)) ? AW'(DEPTH) : len;
    assign we = wr_en && (state == IDLE || state == DONE) && !busy && (wr_addr < AW'(DEPTH));
    stim_ram u_ram (
        .clock   (clock),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (pc),
        .rd_data (op)
    );
    always_ff @(posedge clock) begin
        done <= '0;
        if (!reset) begin
            state <= IDLE;
            pc <= '0;
            last <= '0;
            {obs, k, start} <= '0;
            busy <= '0;
        end else if (abort) begin
            state <= IDLE;
            pc <= '0;
            {obs, k, start} <= '0;
            busy <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    pc <= '0;
                    last <= lim - AW'(1);
                    busy <= (len != '0);
                    state <= (len == '0) ? DONE : RUN;
                end
                RUN, PAUSE: begin
                    // a stalled edge parks in PAUSE; an unstalled PAUSE edge issues straight away
                    if (stall) state <= PAUSE;
                    else begin
                        {obs, k, start} <= {op[OBS_BIT], op[K_MSB:K_LSB], op[START_BIT]};
`ifdef STIM_PLAYER_LOOP_EN
                        pc <= (pc == last) ? '0 : pc + AW'(1);
                        done <= (pc == last);
                        state <= RUN;
`else
                        pc <= pc + AW'(1);
                        state <= (pc == last) ? DONE : RUN;
`endif
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    {obs, k, start} <= '0;
                    busy <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stim_player.sv
// tb_stim_player: directed checks of stim_player playback, stall, abort, boundaries and reset
module tb_stim_player;
    import stim_pkg::*;
    logic clock = 0;
    logic reset = 0;
    logic wr_en = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [OPW-1:0] wr_data = '0;
    logic [AW-1:0] len = '0;
    logic go = 0;
    logic stall = 0;
    logic abort = 0;
    logic busy, done, start, obs;
    logic [AW-1:0] pc;
    logic [KW-1:0] k;
    logic [OPW-1:0] out;
    int n_checks = 0;
    int n_fail = 0;

    stim_player dut (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .len     (len),
        .go      (go),
        .stall   (stall),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .pc      (pc),
        .k       (k),
        .start   (start),
        .obs     (obs)
    );

    always #5 clock = ~clock;
    assign out = {obs, k, start};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int addr, input logic [OPW-1:0] data);
        wr_en = 1;
        wr_addr = AW'(addr);
        wr_data = data;
        tick();
        wr_en = 0;
    endtask

    task automatic launch(input int n);
        len = AW'(n);
        go = 1;
        tick();
        go = 0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pc", pc, 0);
        check("rst_out", out, 0);
        reset = 1;
`ifdef STIM_PLAYER_LOOP_EN
        load(0, 6'b100011);
        load(1, 6'b011110);
        launch(2);
        tick(); check("lp_a1", out, 6'b100011); check("lp_d1", done, 0);
        tick(); check("lp_b1", out, 6'b011110); check("lp_d2", done, 1);
        tick(); check("lp_a2", out, 6'b100011); check("lp_d3", done, 0);
        tick(); check("lp_b2", out, 6'b011110); check("lp_d4", done, 1);
        check("lp_busy", busy, 1);
        tick(); check("lp_a3", out, 6'b100011);
        abort = 1;
        tick(); abort = 0;
        check("lp_abort_out", out, 0);
        check("lp_abort_busy", busy, 0);
`else
        load(0, 6'b100011);
        load(1, 6'b000100);
        load(2, 6'b111111);
        load(500, 6'b011010);
        // single pass
        launch(3);
        check("sp_busy0", busy, 1);
        tick(); check("sp_op1", out, 6'b100011); check("sp_pc1", pc, 1);
        tick(); check("sp_op2", out, 6'b000100); check("sp_pc2", pc, 2);
        load(0, 6'b000000);
        check("sp_op3", out, 6'b111111); check("sp_busy3", busy, 1); check("sp_done3", done, 0);
        tick(); check("sp_done4", done, 1); check("sp_out4", out, 0); check("sp_busy4", busy, 0);
        tick(); check("sp_done5", done, 0);
        // stall
        launch(3);
        tick(); check("st_op1", out, 6'b100011); check("st_pc1", pc, 1);
        stall = 1;
        tick(); check("st_hold2", out, 6'b100011); check("st_pc2", pc, 1);
        tick(); check("st_hold3", out, 6'b100011); check("st_pc3", pc, 1);
        stall = 0;
        tick(); check("st_op2", out, 6'b000100);
        tick(); check("st_op3", out, 6'b111111); check("st_done5", done, 0);
        tick(); check("st_done6", done, 1); check("st_out6", out, 0);
        tick();
        // abort
        launch(3);
        tick();
        abort = 1;
        tick(); abort = 0;
        check("ab_out", out, 0); check("ab_pc", pc, 0); check("ab_busy", busy, 0); check("ab_done", done, 0);
        tick(); check("ab_done_after1", done, 0);
        tick(); check("ab_done_after2", done, 0);
        // go while busy
        launch(3);
        tick(); check("gb_pc1", pc, 1);
        len = 1;
        go = 1;
        tick(); go = 0;
        check("gb_pc2", pc, 2); check("gb_op2", out, 6'b000100);
        tick(); check("gb_op3", out, 6'b111111); check("gb_pc3", pc, 3);
        tick(); check("gb_done", done, 1);
        // zero length
        launch(0);
        check("z_busy", busy, 0); check("z_done0", done, 0);
        tick(); check("z_done1", done, 1); check("z_out", out, 0); check("z_pc", pc, 0);
        // out-of-range write, then oversize length clamps to the full memory
        load(501, 6'b010101);
        launch(511);
        repeat (500) tick();
        check("big_pc500", pc, 500);
        tick(); check("big_pc501", pc, 501); check("big_op501", out, 6'b011010); check("big_done501", done, 0);
        tick(); check("big_done", done, 1); check("big_busy", busy, 0);
        // reset mid-run, then replay the preserved memory
        launch(3);
        tick();
        tick();
        reset = 0;
        tick(); reset = 1;
        check("mr_out", out, 0); check("mr_pc", pc, 0); check("mr_busy", busy, 0); check("mr_done", done, 0);
        launch(3);
        tick(); check("rp_op1", out, 6'b100011);
        tick(); check("rp_op2", out, 6'b000100);
        tick(); check("rp_op3", out, 6'b111111);
        tick(); check("rp_done", done, 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stim_player.md
STIM_PLAYER -- requirements
Module: stim_player

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock input 1, rising-edge system clock; reset input 1, synchronous active-low reset.
REQ-002 The block SHALL provide these ports (name  direction  width  meaning):
  wr_en    input   1   load strobe for the opcode memory
  wr_addr  input   9   load address, 0..500
  wr_data  input   6   opcode: bit5=obs, bits4:1=k, bit0=start
  len      input   9   number of opcodes to play, sampled on go
  go       input   1   playback request pulse
  stall    input   1   freeze playback
  abort    input   1   stop playback immediately
  busy     output  1   high in RUN or PAUSE
  done     output  1   one-cycle end-of-program pulse
  pc       output  9   index of the next opcode to issue
  k        output  4   registered stimulus to the game core
  start    output  1   registered stimulus to the game core
  obs      output  1   registered observation flag

Function
REQ-003 The block SHALL have a 501x6 opcode memory with a combinational read port and one write port; a write takes effect at the clock edge when wr_en=1, state is IDLE or DONE, and wr_addr<=500.
REQ-004 Writes while busy=1 or with wr_addr>500 SHALL be ignored.
REQ-005 The FSM SHALL have four states, IDLE, RUN, PAUSE and DONE, with these transitions:
  - IDLE->RUN on go=1, with pc<=0 and the latched length set to min(len,501).
  - IDLE->DONE on go=1 with len=0.
REQ-006 In RUN with stall=0, each edge SHALL load {obs,k,start}<=mem[pc] and set pc<=pc+1.
  - The first opcode therefore appears on the outputs one cycle after the go edge.
REQ-007 In RUN, when the issued opcode is at pc==latched_len-1, the next state SHALL be DONE.
REQ-008 RUN SHALL go to PAUSE when stall=1; PAUSE SHALL return to RUN when stall=0.
  - In PAUSE, outputs and pc hold their values.
  - Stall is sampled before the issue decision, so a stalled edge issues nothing.
REQ-009 In DONE, the block SHALL assert done=1 for exactly one cycle, drive {obs,k,start}<=0 at that edge, and return to IDLE.
REQ-010 go while busy=1 SHALL be ignored.
REQ-011 abort=1 in any state SHALL force IDLE, {obs,k,start}<=0 and pc<=0 at the next edge, with no done pulse.
  - abort has priority over go, stall and program end.
REQ-012 busy SHALL be a registered decode of RUN|PAUSE; pc SHALL never exceed 501.

Reset
REQ-013 When reset=0 at an edge, the block SHALL set state=IDLE, pc=0, k=0, start=0, obs=0, busy=0 and done=0.
REQ-014 Reset SHALL take priority over every other input, including mid-playback.
REQ-015 Reset SHALL NOT clear the memory contents.

Configuration
REQ-016 With macro STIM_PLAYER_LOOP_EN defined, reaching the program end in RUN SHALL:
  - wrap pc to 0 and stay in RUN;
  - pulse done for one cycle per wrap while the outputs continue with mem[0] on the following edge;
  - continue until abort or reset.
REQ-017 Without STIM_PLAYER_LOOP_EN, the program end SHALL follow REQ-007 and REQ-009 (single pass).

Structure
REQ-018 A shared package stim_pkg SHALL hold the following, and the RTL SHALL use no literal widths:
  - DEPTH=501, AW=9, OPW=6;
  - field positions OBS_BIT=5, K_MSB=4, K_LSB=1, START_BIT=0;
  - the state enum {IDLE,RUN,PAUSE,DONE}.
REQ-019 The memory SHALL be a sub-module stim_ram (one write port, combinational read); the FSM and output registers SHALL live in stim_player.

Verification
REQ-020 Single pass: the bench SHALL cover the following.
  - Stimulus: load mem[0..2]=6'b100011, 6'b000100, 6'b111111; len=3; go.
  - Required response: edges +1..+3 give (obs,k,start)=(1,1,1), (0,2,0), (1,F,1); edge +4 gives done=1 and outputs 0; busy falls at edge +4.
REQ-021 Stall: stall=1 for 2 cycles after the first issued opcode -> the outputs hold (1,1,1) and pc holds at 1 for 2 cycles; done arrives 2 cycles later than in REQ-020.
REQ-022 Abort and go-while-busy: the bench SHALL cover the following.
  - abort at edge +2 of a len=3 run -> outputs 0, pc=0, busy=0, no done pulse.
  - go while busy -> ignored, and pc continues unperturbed.
REQ-023 Boundaries: the bench SHALL cover the following.
  - len=0 -> done pulses one cycle after go, with no opcode issued.
  - len=511 -> playback stops after 501 opcodes.
  - A write at wr_addr=501 -> memory unchanged.
REQ-024 Reset and loop: the bench SHALL cover the following.
  - reset=0 mid-run -> all outputs 0 at that edge; re-running go replays the preserved memory.
  - With STIM_PLAYER_LOOP_EN and len=2, mem={A,B} -> outputs A,B,A,B…, with done=1 on each wrap edge.
